switch_debouncer: RTL and testbench

//  Conditions raw board slide-switch / push-button inputs before they drive the combinational gate stages.
//  Per channel: synchronises the asynchronous input into clk, filters contact bounce, and presents a clean level.

---
 rtl/board_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 88 ++++++++
 rtl/switch_debouncer.sv | 51 +++++
 tb/tb_switch_debouncer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Board-level constants shared by the input-conditioning logic.
//   CLK_HZ           system clock frequency in Hz
//   DEBOUNCE_MS      debounce settle time in milliseconds
//   DEBOUNCE_CYCLES  settle time expressed in clk cycles; callers pass this as
//                    STABLE_CYCLES to switch_debouncer
// No ports (package).
// -----------------------------------------------------------------------------
package board_pkg;

  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Converts a time in milliseconds into a count of clk cycles.
  function automatic int cycles_for_ms(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES = cycles_for_ms(DEBOUNCE_MS);

endpackage : board_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: synchroniser chain, stability counter, registered level
// and one-cycle rise/fall strobes.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   raw_in     in   raw switch/button input, asynchronous to clk
//   level_out  out  debounced level (registered)
//   rise_out   out  one-cycle strobe, level_out went 0->1 this cycle
//   fall_out   out  one-cycle strobe, level_out went 1->0 this cycle
//
// Parameters
//   SYNC_STAGES    flops in the synchroniser chain (>= 2)
//   STABLE_CYCLES  consecutive differing synchronised samples needed to accept
//                  a new level (>= 2)
// -----------------------------------------------------------------------------
module debounce_channel #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int                 CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  // Synchroniser: bit 0 captures the asynchronous pin, the last stage is the
  // only one the rest of the logic looks at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Stability filter. The counter only advances while the synchronised
  // sample disagrees with the accepted level; one agreeing sample throws the
  // pending change away. The change is accepted on the STABLE_CYCLES-th
  // consecutive disagreeing sample, so the counter never needs to exceed
  // STABLE_CYCLES-1 and cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= w_s;
        r_cnt   <= '0;
        // Strobe direction follows the new level, so rise and fall can never
        // be high together.
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // All outputs come straight from flops.
  assign level_out = r_level;
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Conditions raw board slide-switch / push-button inputs before they reach the
// combinational gate stages. Each of the WIDTH channels is synchronised into
// clk, filtered for contact bounce and presented as a clean registered level,
// together with one-cycle rise/fall strobes. Channels are fully independent.
//
// Ports
//   clk        in   1      system clock; the only clock
//   rst        in   1      asynchronous, active-high reset
//   raw_in     in   WIDTH  raw switch/button inputs, asynchronous to clk
//   level_out  out  WIDTH  debounced, registered level per channel
//   rise_out   out  WIDTH  one-cycle strobe: level_out[i] went 0->1
//   fall_out   out  WIDTH  one-cycle strobe: level_out[i] went 1->0
//
// Parameters
//   WIDTH          number of independent input channels
//   SYNC_STAGES    flops per synchroniser chain (>= 2)
//   STABLE_CYCLES  consecutive differing synchronised samples required to
//                  accept a change (>= 2); defaults to the board debounce time
// -----------------------------------------------------------------------------
module switch_debouncer
  import board_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in[g]),
      .level_out (level_out[g]),
      .rise_out  (rise_out[g]),
      .fall_out  (fall_out[g])
    );
  end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Directed scenarios followed by randomised per-channel stimulus. Expected
// outputs come from a behavioural model: the synchroniser is a plain delay
// line, and a channel changes level when the last STABLE_CYCLES delayed
// samples all disagree with the current level.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int W      = 4;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw_in;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_out;
  logic [W-1:0] fall_out;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH         (W),
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_out  (rise_out),
    .fall_out  (fall_out)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] dly_q[$];   // synchroniser as a delay line
  logic [W-1:0] exp_q[$];   // last STABLE synchronised samples
  logic [W-1:0] exp_lvl;
  logic [W-1:0] exp_rise;
  logic [W-1:0] exp_fall;

  task automatic model_reset();
    dly_q.delete();
    for (int k = 0; k < SYNC; k++) dly_q.push_back('0);
    exp_q.delete();
    exp_lvl  = '0;
    exp_rise = '0;
    exp_fall = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    logic         all_diff;
    s = dly_q.pop_front();
    dly_q.push_back(raw_in);
    exp_q.push_back(s);
    if (exp_q.size() > STABLE) void'(exp_q.pop_front());
    exp_rise = '0;
    exp_fall = '0;
    if (exp_q.size() == STABLE) begin
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        foreach (exp_q[k]) if (exp_q[k][i] == exp_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          exp_lvl[i]  = ~exp_lvl[i];
          exp_rise[i] = exp_lvl[i];
          exp_fall[i] = ~exp_lvl[i];
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive raw_in, take one clock edge, advance the model, check 1 time unit
  // after the edge.
  task automatic tick(input logic [W-1:0] v);
    raw_in = v;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    chk("level", level_out, exp_lvl);
    chk("rise",  rise_out,  exp_rise);
    chk("fall",  fall_out,  exp_fall);
    chk("rise_fall_excl", rise_out & fall_out, '0);
  endtask

  // Ticks until level_out[ch] == want, returns the number of edges taken
  // (0 if the budget ran out).
  task automatic ticks_until(input logic [W-1:0] v, input int ch, input logic want,
                             output int lat);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(v);
      if (level_out[ch] === want) begin
        lat = k;
        break;
      end
    end
  endtask

  // Asserts rst between clock edges and checks outputs clear before the
  // next edge, then holds reset over one edge and releases it.
  task automatic async_reset_check(input string tag);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_level"}, level_out, exp_lvl);
    chk({tag, "_rise"},  rise_out,  '0);
    chk({tag, "_fall"},  fall_out,  '0);
    tick(raw_in);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           lat;
    logic [W-1:0] seen;
    logic [W-1:0] cur;
    int           hold[W];

    rst    = 1'b1;
    raw_in = 4'hF;
    model_reset();

    // 1. Reset held with all inputs high, then release.
    repeat (5) tick(4'hF);
    rst = 1'b0;
    ticks_until(4'hF, 3, 1'b1, lat);
    chk_int("reset_release_latency", lat, SYNC + STABLE);
    chk("reset_release_level", level_out, 4'hF);
    chk("reset_release_rise",  rise_out,  4'hF);
    tick(4'hF);
    chk("reset_release_rise_clear", rise_out, 4'h0);

    // 2. Clean step on channel 0, then held.
    repeat (10) tick(4'h0);
    chk("all_low", level_out, 4'h0);
    ticks_until(4'h1, 0, 1'b1, lat);
    chk_int("step_latency", lat, SYNC + STABLE);
    chk("step_rise", rise_out, 4'h1);
    seen = '0;
    repeat (50) begin
      tick(4'h1);
      seen = seen | rise_out | fall_out;
    end
    chk("held_no_restrobe", seen, 4'h0);

    // 3. Bounce on channel 1: 3 high, 1 low, 3 high, then low.
    seen = '0;
    repeat (3)  begin tick(4'h3); seen = seen | rise_out | level_out; end
    tick(4'h1);  seen = seen | rise_out | level_out;
    repeat (3)  begin tick(4'h3); seen = seen | rise_out | level_out; end
    repeat (10) begin tick(4'h1); seen = seen | rise_out | level_out; end
    chk("bounce_ch1_quiet", seen & 4'h2, 4'h0);

    // 4. Simultaneous rise and fall on different channels.
    repeat (10) tick(4'h4);
    chk("pre_simul_level", level_out, 4'h4);
    ticks_until(4'h2, 1, 1'b1, lat);
    chk_int("simul_latency", lat, SYNC + STABLE);
    chk("simul_level", level_out, 4'h2);
    chk("simul_rise",  rise_out,  4'h2);
    chk("simul_fall",  fall_out,  4'h4);

    // 5. Reset pulse mid-count on channel 3.
    repeat (10) tick(4'h0);
    repeat (4)  tick(4'h8);
    chk("midcount_level", level_out, 4'h0);
    rst = 1'b1;
    tick(4'h8);
    rst = 1'b0;
    ticks_until(4'h8, 3, 1'b1, lat);
    chk_int("post_reset_latency", lat, SYNC + STABLE);

    // 6. Asynchronous reset while all levels are high.
    repeat (10) tick(4'hF);
    chk("pre_async_level", level_out, 4'hF);
    async_reset_check("async_rst");

    // Randomised per-channel hold lengths: short holds bounce, long ones
    // settle.
    cur = 4'hF;
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 9);
        end
        hold[i]--;
      end
      tick(cur);
      if (n == 300) async_reset_check("rand_async_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_switch_debouncer
